// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 captures operands/opcode, stage 2 computes and
// registers the result with its status flags behind a valid/ready output port.
module alu_pipe #(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [NBITS-1:0]  i_op_a,
  input  logic [NBITS-1:0]  i_op_b,
  input  logic [COD_OP-1:0] i_cod_op,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NBITS-1:0]  o_result,
  output logic              o_zero,
  output logic              o_negative,
  output logic              o_carry,
  output logic              o_overflow,
  output logic              o_invalid_op
);

  localparam int SHW = $clog2(NBITS);
  localparam int MSB = NBITS - 1;
  localparam logic [NBITS-1:0] MAX_SH = NBITS'(NBITS - 1);

  localparam logic [COD_OP-1:0] OP_ADD = COD_OP'(6'b100000);
  localparam logic [COD_OP-1:0] OP_SUB = COD_OP'(6'b100010);
  localparam logic [COD_OP-1:0] OP_AND = COD_OP'(6'b100100);
  localparam logic [COD_OP-1:0] OP_OR  = COD_OP'(6'b100101);
  localparam logic [COD_OP-1:0] OP_XOR = COD_OP'(6'b100110);
  localparam logic [COD_OP-1:0] OP_SRA = COD_OP'(6'b000011);
  localparam logic [COD_OP-1:0] OP_SRL = COD_OP'(6'b000010);
  localparam logic [COD_OP-1:0] OP_NOR = COD_OP'(6'b100111);

  // Handshake: a word moves across a port at a rising edge where valid & ready
  // are both high. A raised valid and its data hold until that edge. Each stage
  // advances when it is empty or its own content leaves in the same cycle, so
  // o_ready depends combinationally on i_ready (no bubbles under backpressure).
  logic              s1_valid;
  logic [NBITS-1:0]  s1_a;
  logic [NBITS-1:0]  s1_b;
  logic [COD_OP-1:0] s1_op;
  logic              adv2;

  assign adv2    = !o_valid || i_ready;
  assign o_ready = !s1_valid || adv2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_a  <= i_op_a;
        s1_b  <= i_op_b;
        s1_op <= i_cod_op;
      end
    end
  end

  // Arithmetic is done one bit wider so bit NBITS is the carry / borrow.
  logic [NBITS:0]          sum;
  logic [NBITS:0]          diff;
  logic signed [NBITS-1:0] sra_val;
  logic                    shift_big;

  assign sum       = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff      = {1'b0, s1_a} - {1'b0, s1_b};
  assign shift_big = (s1_b > MAX_SH);
  assign sra_val   = $signed(s1_a) >>> s1_b[SHW-1:0];

  logic [NBITS-1:0] res;
  logic             carry;
  logic             ovf;
  logic             inv;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    inv   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = sum[NBITS-1:0];
        carry = sum[NBITS];
        ovf   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        res   = diff[NBITS-1:0];
        carry = diff[NBITS];
        ovf   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_NOR: res = ~(s1_a | s1_b);
      OP_SRL: res = shift_big ? '0 : (s1_a >> s1_b[SHW-1:0]);
      OP_SRA: res = shift_big ? {NBITS{s1_a[MSB]}} : sra_val;
      default: begin
        res = '1;
        inv = 1'b1;
      end
    endcase
  end

  // Result and flags load together, so they always describe one transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_zero       <= 1'b0;
      o_negative   <= 1'b0;
      o_carry      <= 1'b0;
      o_overflow   <= 1'b0;
      o_invalid_op <= 1'b0;
    end else if (adv2) begin
      o_valid      <= s1_valid;
      o_result     <= res;
      o_zero       <= (res == '0);
      o_negative   <= res[MSB];
      o_carry      <= carry;
      o_overflow   <= ovf;
      o_invalid_op <= inv;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and scoreboarded checks of alu_pipe at NBITS=8: hand-computed vectors,
// streaming, backpressure, random ready toggling and asynchronous reset.
module tb_alu_pipe;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_op_a = '0;
  logic [7:0] i_op_b = '0;
  logic [5:0] i_cod_op = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_result;
  logic       o_zero, o_negative, o_carry, o_overflow, o_invalid_op;

  alu_pipe #(.NBITS(8), .COD_OP(6)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_cod_op(i_cod_op),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_zero(o_zero), .o_negative(o_negative),
    .o_carry(o_carry), .o_overflow(o_overflow), .o_invalid_op(o_invalid_op)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int stall_cnt = 0;
  bit rand_ready_en = 1'b0;
  logic [12:0] exp_q[$];

  // packed layout: {invalid, carry, overflow, negative, zero, result[7:0]}
  function automatic logic [12:0] dut_word();
    return {o_invalid_op, o_carry, o_overflow, o_negative, o_zero, o_result};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written with signed integer arithmetic.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    int ua, ub, sa, sb, r;
    logic c, v, inv;
    logic [7:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; inv = 1'b0; r = 0;
    case (op)
      OP_ADD: begin
        r = ua + ub; res = r[7:0]; c = (r > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      OP_SUB: begin
        r = ua - ub; res = r[7:0]; c = (ua < ub);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SRL: res = (ub >= 8) ? 8'h00 : 8'(a >> ub);
      OP_SRA: begin
        r = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
        res = r[7:0];
      end
      default: begin res = 8'hFF; inv = 1'b1; end
    endcase
    return {inv, c, v, res[7], (res == 8'h00), res};
  endfunction

  // ---------------- scoreboard monitor (negedge, between drive and edge) ----------------
  logic [12:0] held_w;
  bit          held_v = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (i_valid && o_ready) exp_q.push_back(model(i_op_a, i_op_b, i_cod_op));
        if (o_valid && i_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) check("unexpected_output", 32'(dut_word()), 32'h1FFFF);
          else check("sb_result", 32'(dut_word()), 32'(exp_q.pop_front()));
        end
        if (o_valid && !i_ready) begin
          if (held_v) check("stall_stable", 32'(dut_word()), 32'(held_w));
          held_w = dut_word();
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) i_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", out_cnt, -1);
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bit done;
    done = 1'b0;
    i_op_a = a; i_op_b = b; i_cod_op = op; i_valid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (o_ready) done = 1'b1;
      else stall_cnt++;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed op with fixed latency check; flags = {inv, carry, ovf, neg, zero}.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] op, input logic [7:0] exp_r,
                        input logic [4:0] exp_f);
    i_ready = 1'b1;
    i_op_a = a; i_op_b = b; i_cod_op = op; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check({tag, "_lat1"}, 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_result"}, 32'(o_result), 32'(exp_r));
    check({tag, "_flags"},
          32'({o_invalid_op, o_carry, o_overflow, o_negative, o_zero}), 32'(exp_f));
  endtask

  logic [5:0] ops[9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                         OP_SRA, OP_SRL, OP_NOR, OP_BAD};

  function automatic logic [7:0] rand_b();
    return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 255));
  endfunction

  // ---------------- main sequence ----------------
  int base, st;
  initial begin
    #2;
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_word", 32'(dut_word()), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("reset_o_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;

    //       tag        A      B      op      result   {inv,c,v,n,z}
    run_op("add_ovf",  8'h7F, 8'h01, OP_ADD, 8'h80, 5'b00110);
    run_op("add_carry",8'hFF, 8'h01, OP_ADD, 8'h00, 5'b01001);
    run_op("sub_borr", 8'h05, 8'h07, OP_SUB, 8'hFE, 5'b01010);
    run_op("sub_ovf",  8'h80, 8'h01, OP_SUB, 8'h7F, 5'b00100);
    run_op("sra_2",    8'h90, 8'h02, OP_SRA, 8'hE4, 5'b00010);
    run_op("sra_9",    8'h90, 8'h09, OP_SRA, 8'hFF, 5'b00010);
    run_op("srl_8",    8'h90, 8'h08, OP_SRL, 8'h00, 5'b00001);
    run_op("srl_3",    8'h90, 8'h03, OP_SRL, 8'h12, 5'b00000);
    run_op("and",      8'hF0, 8'h3C, OP_AND, 8'h30, 5'b00000);
    run_op("or",       8'hF0, 8'h0C, OP_OR,  8'hFC, 5'b00010);
    run_op("xor",      8'hAA, 8'hAA, OP_XOR, 8'h00, 5'b00001);
    run_op("nor",      8'h0F, 8'hF0, OP_NOR, 8'h00, 5'b00001);
    run_op("invalid",  8'h12, 8'h34, OP_BAD, 8'hFF, 5'b10010);
    drain();

    // Streaming: 20 back-to-back ops, never stalled, 20 results one cycle after fill.
    base = out_cnt;
    st = stall_cnt;
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), rand_b(), ops[$urandom_range(0, 8)]);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("stream_no_stall", 32'(stall_cnt - st), 32'd0);
    check("stream_out_cnt", 32'(out_cnt - base), 32'd20);
    drain();

    // Backpressure: two ops fill the pipe, third is refused until release.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    base = out_cnt;
    send(8'h7F, 8'h01, OP_ADD);
    send(8'h05, 8'h07, OP_SUB);
    i_op_a = 8'h90; i_op_b = 8'h02; i_cod_op = OP_SRA; i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_o_ready", 32'(o_ready), 32'd0);
      check("bp_hold_result", 32'(o_result), 32'h80);
    end
    check("bp_queued", 32'(exp_q.size()), 32'd2);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    send(8'h90, 8'h02, OP_SRA);
    drain();
    check("bp_out_cnt", 32'(out_cnt - base), 32'd3);

    // Random ready toggling over 100 ops with occasional input gaps.
    base = out_cnt;
    rand_ready_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(8'($urandom_range(0, 255)), rand_b(), ops[$urandom_range(0, 8)]);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    drain();
    check("rand_out_cnt", 32'(out_cnt - base), 32'd100);

    // Asynchronous reset mid-cycle with both stages full.
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send(8'h7F, 8'h01, OP_ADD);
    send(8'hFF, 8'h01, OP_ADD);
    @(negedge clk);
    check("pre_reset_valid", 32'(o_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'd0);
    check("arst_word", 32'(dut_word()), 32'd0);
    exp_q.delete();
    base = out_cnt;
    @(posedge clk);
    #3 reset = 1'b0;
    i_ready = 1'b1;
    #1 check("arst_o_ready", 32'(o_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("arst_no_stale", 32'(o_valid), 32'd0);
    end
    check("arst_out_cnt", 32'(out_cnt - base), 32'd0);
    run_op("post_rst", 8'h01, 8'h02, OP_ADD, 8'h03, 5'b00000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
